// File: rtl/triangle_projection_sequencer.sv
`timescale 1ns/1ps
// triangle_projection_sequencer
//
// Feeds whole triangles, one vertex at a time, through a single shared
// vertex projector. It collects the three projected x/y/z results and
// presents one projected triangle downstream. If the projector
// short-circuits any vertex, the triangle is culled and no further vertices
// are issued. A triangle whose projector never answers is abandoned after
// TIMEOUT cycles in WAIT and counted as culled.
//
// Ports
//   clk_in, rst_in            clock; asynchronous active-high reset
//   tri_valid_in/_ready_out   upstream triangle handshake
//   tri_vertices, tri_id_in   triangle vertices [v][axis] and ID
//   proj_valid_out/_ready_in  vertex issue handshake to the projector
//   proj_P                    vertex presented to the projector
//   proj_ready_out            result acceptance towards the projector
//   proj_valid_in             projector result valid (may stay high)
//   proj_short_circuit_in     projector short-circuit flag
//   proj_x/y/z_in             projected coordinates
//   tri_valid_out/_ready_in   downstream projected-triangle handshake
//   tri_x/y/z_out, tri_id_out projected triangle
//   cull_count                saturating count of culled triangles
//   timeout_err               sticky timeout flag
module triangle_projection_sequencer #(
    parameter int P_WIDTH                   = 16,
    parameter int VIEWPORT_W_POSITION_WIDTH = 20,
    parameter int VIEWPORT_H_POSITION_WIDTH = 18,
    parameter int ZWIDTH                    = 16,
    parameter int ID_WIDTH                  = 12,
    parameter int TIMEOUT                   = 256
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic                                          tri_valid_in,
    output logic                                          tri_ready_out,
    input  logic [2:0][2:0][P_WIDTH-1:0]                  tri_vertices,
    input  logic [ID_WIDTH-1:0]                           tri_id_in,
    output logic                                          proj_valid_out,
    input  logic                                          proj_ready_in,
    output logic [2:0][P_WIDTH-1:0]                       proj_P,
    output logic                                          proj_ready_out,
    input  logic                                          proj_valid_in,
    input  logic                                          proj_short_circuit_in,
    input  logic [VIEWPORT_W_POSITION_WIDTH-1:0]          proj_x_in,
    input  logic [VIEWPORT_H_POSITION_WIDTH-1:0]          proj_y_in,
    input  logic [ZWIDTH-1:0]                             proj_z_in,
    output logic                                          tri_valid_out,
    input  logic                                          tri_ready_in,
    output logic [2:0][VIEWPORT_W_POSITION_WIDTH-1:0]     tri_x_out,
    output logic [2:0][VIEWPORT_H_POSITION_WIDTH-1:0]     tri_y_out,
    output logic [2:0][ZWIDTH-1:0]                        tri_z_out,
    output logic [ID_WIDTH-1:0]                           tri_id_out,
    output logic [15:0]                                   cull_count,
    output logic                                          timeout_err
);

    localparam int XW    = VIEWPORT_W_POSITION_WIDTH;
    localparam int YW    = VIEWPORT_H_POSITION_WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                          state_q;
    logic [1:0]                      vi_q;
    logic [2:0][2:0][P_WIDTH-1:0]    vert_q;
    logic [ID_WIDTH-1:0]             id_q;
    logic [2:0][P_WIDTH-1:0]         proj_p_q;
    logic                            proj_valid_q;
    logic                            valid_q;
    logic [CNT_W-1:0]                wait_cnt_q;
    // Results of vertices 0 and 1; vertex 2 goes straight to the outputs.
    logic [1:0][XW-1:0]              x_slot_q;
    logic [1:0][YW-1:0]              y_slot_q;
    logic [1:0][ZWIDTH-1:0]          z_slot_q;
    logic [2:0][XW-1:0]              tri_x_q;
    logic [2:0][YW-1:0]              tri_y_q;
    logic [2:0][ZWIDTH-1:0]          tri_z_q;
    logic [ID_WIDTH-1:0]             tri_id_q;
    logic [15:0]                     cull_q;
    logic                            timeout_q;

    logic                            rise_d;
    logic                            wait_last_d;
    logic [1:0]                      vi_d;
    logic [15:0]                     cull_d;

    // Only a fresh rising edge counts as a result, so a valid left high by
    // the projector from the previous vertex is never taken as new data.
    assign rise_d      = proj_valid_in && !valid_q;
    assign wait_last_d = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
    assign vi_d        = vi_q + 2'd1;
    assign cull_d      = sat_inc16(cull_q);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            vi_q         <= 2'd0;
            vert_q       <= '0;
            id_q         <= '0;
            proj_p_q     <= '0;
            proj_valid_q <= 1'b0;
            valid_q      <= 1'b0;
            wait_cnt_q   <= '0;
            x_slot_q     <= '0;
            y_slot_q     <= '0;
            z_slot_q     <= '0;
            tri_x_q      <= '0;
            tri_y_q      <= '0;
            tri_z_q      <= '0;
            tri_id_q     <= '0;
            cull_q       <= 16'd0;
            timeout_q    <= 1'b0;
        end else begin
            valid_q      <= proj_valid_in;
            proj_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tri_valid_in) begin
                        vert_q   <= tri_vertices;
                        id_q     <= tri_id_in;
                        vi_q     <= 2'd0;
                        proj_p_q <= tri_vertices[0];
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Single-cycle issue pulse; the vertex stays on proj_P
                    // for the whole wait.
                    if (proj_ready_in) begin
                        proj_valid_q <= 1'b1;
                        wait_cnt_q   <= '0;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    if (proj_short_circuit_in) begin
                        cull_q  <= cull_d;
                        state_q <= S_IDLE;
                    end else if (rise_d) begin
                        if (vi_q == 2'd2) begin
                            tri_x_q  <= {proj_x_in, x_slot_q[1], x_slot_q[0]};
                            tri_y_q  <= {proj_y_in, y_slot_q[1], y_slot_q[0]};
                            tri_z_q  <= {proj_z_in, z_slot_q[1], z_slot_q[0]};
                            tri_id_q <= id_q;
                            state_q  <= S_EMIT;
                        end else begin
                            x_slot_q[vi_q[0]] <= proj_x_in;
                            y_slot_q[vi_q[0]] <= proj_y_in;
                            z_slot_q[vi_q[0]] <= proj_z_in;
                            vi_q              <= vi_d;
                            proj_p_q          <= vert_q[vi_d];
                            state_q           <= S_ISSUE;
                        end
                    end else if (wait_last_d) begin
                        timeout_q <= 1'b1;
                        cull_q    <= cull_d;
                        state_q   <= S_IDLE;
                    end
                end
                S_EMIT: begin
                    if (tri_ready_in) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tri_ready_out  = (state_q == S_IDLE);
    assign proj_ready_out = (state_q == S_WAIT);
    assign tri_valid_out  = (state_q == S_EMIT);
    assign proj_valid_out = proj_valid_q;
    assign proj_P         = proj_p_q;
    assign tri_x_out      = tri_x_q;
    assign tri_y_out      = tri_y_q;
    assign tri_z_out      = tri_z_q;
    assign tri_id_out     = tri_id_q;
    assign cull_count     = cull_q;
    assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_triangle_projection_sequencer.sv
`timescale 1ns/1ps
module tb_triangle_projection_sequencer;

    localparam int PW = 16;
    localparam int XW = 20;
    localparam int YW = 18;
    localparam int ZW = 16;
    localparam int IW = 12;
    localparam int TO = 64;

    logic                      clk_in = 1'b0;
    logic                      rst_in;
    logic                      tri_valid_in;
    logic                      tri_ready_out;
    logic [2:0][2:0][PW-1:0]   tri_vertices;
    logic [IW-1:0]             tri_id_in;
    logic                      proj_valid_out;
    logic                      proj_ready_in;
    logic [2:0][PW-1:0]        proj_P;
    logic                      proj_ready_out;
    logic                      proj_valid_in;
    logic                      proj_short_circuit_in;
    logic [XW-1:0]             proj_x_in;
    logic [YW-1:0]             proj_y_in;
    logic [ZW-1:0]             proj_z_in;
    logic                      tri_valid_out;
    logic                      tri_ready_in;
    logic [2:0][XW-1:0]        tri_x_out;
    logic [2:0][YW-1:0]        tri_y_out;
    logic [2:0][ZW-1:0]        tri_z_out;
    logic [IW-1:0]             tri_id_out;
    logic [15:0]               cull_count;
    logic                      timeout_err;

    triangle_projection_sequencer #(
        .P_WIDTH(PW), .VIEWPORT_W_POSITION_WIDTH(XW), .VIEWPORT_H_POSITION_WIDTH(YW),
        .ZWIDTH(ZW), .ID_WIDTH(IW), .TIMEOUT(TO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .tri_valid_in(tri_valid_in), .tri_ready_out(tri_ready_out),
        .tri_vertices(tri_vertices), .tri_id_in(tri_id_in),
        .proj_valid_out(proj_valid_out), .proj_ready_in(proj_ready_in),
        .proj_P(proj_P), .proj_ready_out(proj_ready_out),
        .proj_valid_in(proj_valid_in), .proj_short_circuit_in(proj_short_circuit_in),
        .proj_x_in(proj_x_in), .proj_y_in(proj_y_in), .proj_z_in(proj_z_in),
        .tri_valid_out(tri_valid_out), .tri_ready_in(tri_ready_in),
        .tri_x_out(tri_x_out), .tri_y_out(tri_y_out), .tri_z_out(tri_z_out),
        .tri_id_out(tri_id_out), .cull_count(cull_count), .timeout_err(timeout_err)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected projected triangle: the projector stub maps a vertex (x,y,z)
    // to (100+x, 50+y, 200+z), so a triangle's result follows directly from
    // its vertex list, in vertex order.
    typedef struct packed {
        logic [2:0][XW-1:0] x;
        logic [2:0][YW-1:0] y;
        logic [2:0][ZW-1:0] z;
        logic [IW-1:0]      id;
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t model_tri(input logic [2:0][2:0][PW-1:0] v, input logic [IW-1:0] id);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.x[k] = XW'(100 + int'(v[k][0]));
            e.y[k] = YW'(50 + int'(v[k][1]));
            e.z[k] = ZW'(200 + int'(v[k][2]));
        end
        e.id = id;
        return e;
    endfunction

    function automatic logic [2:0][2:0][PW-1:0] mk(input int bx, input int by, input int bz);
        logic [2:0][2:0][PW-1:0] v;
        for (int k = 0; k < 3; k++) begin
            v[k][0] = PW'(bx + k);
            v[k][1] = PW'(by + k);
            v[k][2] = PW'(bz + k);
        end
        return v;
    endfunction

    // Projector stub
    int stub_lat    = 20;
    bit stub_hold   = 1'b0;
    bit stub_noresp = 1'b0;
    int sc_vertex   = -1;
    int pulses      = 0;

    initial begin
        int                 cnt;
        bit                 busy;
        int                 cur;
        logic [2:0][PW-1:0] cap;
        cnt = 0; busy = 1'b0; cur = 0; cap = '0;
        proj_valid_in = 1'b0; proj_short_circuit_in = 1'b0;
        proj_x_in = '0; proj_y_in = '0; proj_z_in = '0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                busy = 1'b0;
                proj_valid_in = 1'b0;
                proj_short_circuit_in = 1'b0;
            end else begin
                proj_short_circuit_in = 1'b0;
                if (!stub_hold) proj_valid_in = 1'b0;
                if (proj_valid_out) begin
                    cap = proj_P; cur = pulses; pulses++;
                    cnt = stub_lat; busy = !stub_noresp;
                end else if (busy) begin
                    cnt--;
                    if (stub_hold && cnt == 1) proj_valid_in = 1'b0;
                    if (cnt == 0) begin
                        busy = 1'b0;
                        proj_valid_in = 1'b1;
                        proj_x_in = XW'(100 + int'(cap[0]));
                        proj_y_in = YW'(50 + int'(cap[1]));
                        proj_z_in = ZW'(200 + int'(cap[2]));
                        if (cur == sc_vertex) proj_short_circuit_in = 1'b1;
                    end
                end
            end
        end
    end

    // Compare process: every cycle a triangle is presented it must match the
    // oldest outstanding expectation; issue pulses must be one cycle wide.
    bit prev_pv = 1'b0;
    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_pv = 1'b0;
        end else begin
            if (tri_valid_out) begin
                check("emit_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    check("tri_x", tri_x_out, sb_q[0].x);
                    check("tri_y", tri_y_out, sb_q[0].y);
                    check("tri_z", tri_z_out, sb_q[0].z);
                    check("tri_id", tri_id_out, sb_q[0].id);
                end
            end
            if (proj_valid_out) check("issue_pulse_width", prev_pv, 1'b0);
            prev_pv = proj_valid_out;
        end
    end

    always @(posedge clk_in) begin
        if (!rst_in && tri_valid_out && tri_ready_in && sb_q.size() != 0)
            void'(sb_q.pop_front());
    end

    task automatic send_tri(input logic [2:0][2:0][PW-1:0] v, input logic [IW-1:0] id, input bit expect_done);
        int n;
        n = 0;
        @(negedge clk_in);
        tri_vertices = v; tri_id_in = id; tri_valid_in = 1'b1;
        if (expect_done) sb_q.push_back(model_tri(v, id));
        while (!tri_ready_out && n < 300) begin
            @(negedge clk_in); n++;
        end
        check("accept_timeout", 64'(n >= 300), 64'd0);
        @(negedge clk_in);
        tri_valid_in = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || tri_valid_out) && n < 500) begin
            @(negedge clk_in); n++;
        end
        check(name, 64'(n >= 500), 64'd0);
    endtask

    task automatic wait_emit(input string name);
        int n;
        n = 0;
        while (!tri_valid_out && n < 500) begin
            @(negedge clk_in); n++;
        end
        check(name, 64'(n >= 500), 64'd0);
    endtask

    initial begin
        int n;
        int p0;
        logic [2:0][2:0][PW-1:0] v;
        rst_in = 1'b1; tri_valid_in = 1'b0; tri_vertices = '0; tri_id_in = '0;
        proj_ready_in = 1'b1; tri_ready_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rst_tri_ready", tri_ready_out, 1'b1);
        check("rst_proj_valid", proj_valid_out, 1'b0);
        check("rst_proj_ready", proj_ready_out, 1'b0);
        check("rst_tri_valid", tri_valid_out, 1'b0);
        check("rst_cull", cull_count, 16'd0);
        check("rst_timeout", timeout_err, 1'b0);
        rst_in = 1'b0;

        // Basic triangle, ID 7, projector latency 20
        p0 = pulses;
        send_tri(mk(0, 0, 0), 12'd7, 1'b1);
        wait_emit("t1_emit_timeout");
        check("t1_x_lit", tri_x_out, {20'd102, 20'd101, 20'd100});
        check("t1_y_lit", tri_y_out, {18'd52, 18'd51, 18'd50});
        check("t1_z_lit", tri_z_out, {16'd202, 16'd201, 16'd200});
        check("t1_id_lit", tri_id_out, 12'd7);
        check("t1_cull", cull_count, 16'd0);
        wait_drain("t1_drain_timeout");
        check("t1_pulses", 64'(pulses - p0), 64'd3);

        // Short-circuit on vertex 1
        p0 = pulses;
        sc_vertex = p0 + 1;
        send_tri(mk(3, 3, 3), 12'd9, 1'b0);
        n = 0;
        do begin
            @(negedge clk_in); #1; n++;
        end while (!proj_short_circuit_in && n < 300);
        check("t2_sc_timeout", 64'(n >= 300), 64'd0);
        check("t2_busy_at_sc", tri_ready_out, 1'b0);
        @(negedge clk_in); #1;
        check("t2_idle_after_sc", tri_ready_out, 1'b1);
        check("t2_cull", cull_count, 16'd1);
        sc_vertex = -1;
        repeat (40) @(negedge clk_in);
        check("t2_pulses", 64'(pulses - p0), 64'd2);
        check("t2_cull_hold", cull_count, 16'd1);

        // Projector valid held high across vertices
        stub_hold = 1'b1;
        send_tri(mk(10, 20, 30), 12'h055, 1'b1);
        wait_emit("t3_emit_timeout");
        check("t3_x_lit", tri_x_out, {20'd112, 20'd111, 20'd110});
        wait_drain("t3_drain_timeout");
        stub_hold = 1'b0;
        repeat (3) @(negedge clk_in);

        // Projector not ready, then downstream back-pressure during EMIT
        stub_lat = 5;
        tri_ready_in = 1'b0;
        proj_ready_in = 1'b0;
        p0 = pulses;
        v = mk(40, 41, 42);
        send_tri(v, 12'h123, 1'b1);
        repeat (5) @(negedge clk_in);
        check("t4_issue_held", 64'(pulses - p0), 64'd0);
        check("t4_proj_P", proj_P, v[0]);
        proj_ready_in = 1'b1;
        wait_emit("t4_emit_timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (i == 2) begin
                v = mk(50, 50, 50);
                tri_vertices = v; tri_id_in = 12'h124; tri_valid_in = 1'b1;
                sb_q.push_back(model_tri(v, 12'h124));
            end
            check("t4_valid_held", tri_valid_out, 1'b1);
            check("t4_not_ready", tri_ready_out, 1'b0);
        end
        check("t4_no_second_issue", 64'(pulses - p0), 64'd3);
        tri_ready_in = 1'b1;
        n = 0;
        while (!tri_ready_out && n < 50) begin
            @(negedge clk_in); n++;
        end
        check("t4_accept_timeout", 64'(n >= 50), 64'd0);
        @(negedge clk_in);
        tri_valid_in = 1'b0;
        wait_drain("t4_drain_timeout");
        check("t4_pulses", 64'(pulses - p0), 64'd6);

        // Projector never answers: timeout
        stub_noresp = 1'b1;
        p0 = pulses;
        send_tri(mk(1, 2, 3), 12'h0AA, 1'b0);
        n = 0;
        while (!proj_ready_out && n < 50) begin
            @(negedge clk_in); n++;
        end
        check("t5_wait_entry_timeout", 64'(n >= 50), 64'd0);
        n = 0;
        while (proj_ready_out && n < 200) begin
            n++; @(negedge clk_in);
        end
        check("t5_wait_cycles", 64'(n), 64'(TO));
        check("t5_idle", tri_ready_out, 1'b1);
        check("t5_timeout_err", timeout_err, 1'b1);
        check("t5_cull", cull_count, 16'd2);
        check("t5_pulses", 64'(pulses - p0), 64'd1);
        stub_noresp = 1'b0;
        send_tri(mk(5, 6, 7), 12'h0BB, 1'b1);
        wait_drain("t5_drain_timeout");
        check("t5_timeout_sticky", timeout_err, 1'b1);
        check("t5_cull_hold", cull_count, 16'd2);

        // Asynchronous reset in the middle of WAIT
        stub_lat = 20;
        send_tri(mk(8, 8, 8), 12'h0CC, 1'b0);
        n = 0;
        while (!proj_ready_out && n < 50) begin
            @(negedge clk_in); n++;
        end
        check("t6_wait_entry_timeout", 64'(n >= 50), 64'd0);
        repeat (3) @(negedge clk_in);
        #1 rst_in = 1'b1;
        #1;
        check("t6_tri_ready", tri_ready_out, 1'b1);
        check("t6_proj_valid", proj_valid_out, 1'b0);
        check("t6_proj_ready", proj_ready_out, 1'b0);
        check("t6_tri_valid", tri_valid_out, 1'b0);
        check("t6_cull", cull_count, 16'd0);
        check("t6_timeout_err", timeout_err, 1'b0);
        check("t6_proj_P", proj_P, 48'd0);
        check("t6_tri_x", tri_x_out, 60'd0);
        check("t6_tri_id", tri_id_out, 12'd0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        send_tri(mk(20, 21, 22), 12'h0DD, 1'b1);
        wait_emit("t6_emit_timeout");
        check("t6_x_lit", tri_x_out, {20'd122, 20'd121, 20'd120});
        wait_drain("t6_drain_timeout");
        check("t6_cull_after", cull_count, 16'd0);

        repeat (3) @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
